// File: rtl/cdc_src_flush_buffer.sv
// Source-side front end for the clearable two-phase CDC: a small FIFO feeding the
// CDC source port, with clear sequencing and a saturating count of discarded items.
//
// state     | meaning
// RUN       | normal streaming; local flush requests are accepted or deferred here
// ISSUE     | one cycle: cdc_clear_o high, FIFO emptied, drop count updated
// WAIT_RISE | clear issued, waiting for the CDC to report it pending
// WAIT_FALL | waiting for the CDC to finish the clear
module cdc_src_flush_buffer #(
   parameter type         T               = logic,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned CNT_W           = 16,
   parameter logic        FLUSH_ON_REMOTE = 1'b1
) (
   input  logic                       src_clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   output logic                       flush_busy_o,
   input  T                           in_data_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   output T                           cdc_data_o,
   output logic                       cdc_valid_o,
   input  logic                       cdc_ready_i,
   output logic                       cdc_clear_o,
   input  logic                       cdc_clear_pending_i,
   output logic [$clog2(DEPTH+1)-1:0] fill_o,
   output logic [CNT_W-1:0]           dropped_cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);
   localparam int SW = CNT_W + FW;

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_ISSUE     = 2'd1;
   localparam logic [1:0] ST_WAIT_RISE = 2'd2;
   localparam logic [1:0] ST_WAIT_FALL = 2'd3;

   T                r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [FW-1:0]   r_fill;
   logic [1:0]      r_state;
   logic            r_flush_pend;
   logic            r_pend_q;
   logic [CNT_W-1:0] r_dropped;

   logic            w_full;
   logic            w_empty;
   logic            w_gate;
   logic            w_push;
   logic            w_pop;
   logic            w_remote_rise;
   logic            w_drop_all;
   logic [SW-1:0]   w_sum;
   logic [CNT_W-1:0] w_dropped_nxt;

   assign w_full        = (r_fill == FW'(DEPTH));
   assign w_empty       = (r_fill == '0);
   assign w_gate        = (r_state != ST_RUN) || cdc_clear_pending_i;
   assign w_push        = in_valid_i && in_ready_o;
   assign w_pop         = cdc_valid_o && cdc_ready_i;
   // Only a pending edge seen while idle is a remote clear; our own clears arrive in WAIT_RISE.
   assign w_remote_rise = cdc_clear_pending_i && !r_pend_q && (r_state == ST_RUN);
   assign w_drop_all    = (r_state == ST_ISSUE) || (FLUSH_ON_REMOTE && w_remote_rise);

   assign w_sum         = SW'(r_dropped) + SW'(r_fill);
   assign w_dropped_nxt = (w_sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

   assign in_ready_o    = !w_full && !w_gate;
   assign cdc_valid_o   = !w_empty && !w_gate;
   assign cdc_data_o    = r_mem[r_rd_ptr];
   assign cdc_clear_o   = (r_state == ST_ISSUE);
   assign flush_busy_o  = (r_state != ST_RUN) || r_flush_pend;
   assign fill_o        = r_fill;
   assign dropped_cnt_o = r_dropped;

   always_ff @(posedge src_clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= in_data_i;
   end

   // Push and pop are both gated off whenever a drop-all fires, so emptying never races a push.
   always_ff @(posedge src_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else if (w_drop_all) begin
         r_rd_ptr <= r_wr_ptr;
         r_fill   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + FW'(1);
            2'b01:   r_fill <= r_fill - FW'(1);
            default: r_fill <= r_fill;
         endcase
      end
   end

   always_ff @(posedge src_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_RUN;
         r_flush_pend <= 1'b0;
         r_pend_q     <= 1'b0;
         r_dropped    <= '0;
      end else begin
         r_pend_q <= cdc_clear_pending_i;
         if (w_drop_all) r_dropped <= w_dropped_nxt;
         case (r_state)
            ST_RUN: begin
               if ((flush_i || r_flush_pend) && !cdc_clear_pending_i) begin
                  r_state      <= ST_ISSUE;
                  r_flush_pend <= 1'b0;
               end else if (flush_i) begin
                  r_flush_pend <= 1'b1;
               end
            end
            ST_ISSUE:     r_state <= ST_WAIT_RISE;
            ST_WAIT_RISE: if (cdc_clear_pending_i)  r_state <= ST_WAIT_FALL;
            ST_WAIT_FALL: if (!cdc_clear_pending_i) r_state <= ST_RUN;
            default:      r_state <= ST_RUN;
         endcase
      end
   end

endmodule
